// File: rtl/gift_word_io.sv
// gift_word_io
// Word-serial front end for a 128-bit GiftEnc block-cipher core.
// Upstream 32-bit words are routed into a key buffer or a data buffer. Each
// buffer fills most-significant word first. When the fourth data word
// arrives, both buffers are written into the core with a one-cycle strobe.
// The block then waits for the core busy flag to rise and fall, captures the
// ciphertext, and streams it downstream as four 32-bit words, MSW first.
//
// Ports
//   inClk, inRstN                single clock, async active-low reset
//   inWordValid/Data/IsKey       upstream word stream (IsKey routes the word)
//   outWordReady                 word acceptance
//   outKeyWr/outKeyData          key write strobe and key to the core
//   outDataWr/outDataData        plaintext write strobe and plaintext to core
//   inCoreData, inCoreBusy       core ciphertext and busy flag
//   outResValid/outResData       result word stream
//   inResReady                   downstream acceptance
//   outErr                       sticky core-timeout flag
module gift_word_io #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic         inClk,
    input  logic         inRstN,
    input  logic         inWordValid,
    input  logic [31:0]  inWordData,
    input  logic         inWordIsKey,
    output logic         outWordReady,
    output logic         outKeyWr,
    output logic [127:0] outKeyData,
    output logic         outDataWr,
    output logic [127:0] outDataData,
    input  logic [127:0] inCoreData,
    input  logic         inCoreBusy,
    output logic         outResValid,
    output logic [31:0]  outResData,
    input  logic         inResReady,
    output logic         outErr
);

    typedef enum logic [2:0] {LOAD, FIRE, WAIT_HI, WAIT_LO, SEND} stateT;

    stateT        state;
    stateT        stateNext;
    logic [127:0] keyBuf;
    logic [127:0] dataBuf;
    logic [127:0] resReg;
    logic [1:0]   kcnt;
    logic [1:0]   dcnt;
    logic [1:0]   rcnt;
    logic [7:0]   tcnt;
    logic         keyValid;
    logic         errFlag;
    logic         wordFire;
    logic         resFire;
    logic         timeoutHit;
    logic         inWait;

    assign wordFire = inWordValid && outWordReady;
    assign resFire  = outResValid && inResReady;
    assign inWait   = (state == WAIT_HI) || (state == WAIT_LO);

    // The cycle being spent now is number tcnt+1 in this wait state; the
    // block gives up once that count reaches TIMEOUT_CYC.
    assign timeoutHit = (({1'b0, tcnt} + 9'd1) == 9'(TIMEOUT_CYC));

    // Buffers only change in LOAD, so they already stay stable from FIRE
    // until SEND completes and can feed the core directly.
    assign outKeyData  = keyBuf;
    assign outDataData = dataBuf;
    assign outResData  = resReg[{~rcnt, 5'd0} +: 32];
    assign outErr      = errFlag;

    // State register.
    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            state <= LOAD;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and strobe decode. Data words are held off until a full
    // key is present; key words are always welcome in LOAD.
    always_comb begin
        stateNext    = state;
        outWordReady = 1'b0;
        outKeyWr     = 1'b0;
        outDataWr    = 1'b0;
        outResValid  = 1'b0;
        case (state)
            LOAD: begin
                outWordReady = inWordIsKey || keyValid;
                if (wordFire && !inWordIsKey && (dcnt == 2'd3)) begin
                    stateNext = FIRE;
                end
            end
            FIRE: begin
                outKeyWr  = 1'b1;
                outDataWr = 1'b1;
                stateNext = WAIT_HI;
            end
            WAIT_HI: begin
                if (inCoreBusy) begin
                    stateNext = WAIT_LO;
                end else if (timeoutHit) begin
                    stateNext = LOAD;
                end
            end
            WAIT_LO: begin
                if (!inCoreBusy) begin
                    stateNext = SEND;
                end else if (timeoutHit) begin
                    stateNext = LOAD;
                end
            end
            SEND: begin
                outResValid = 1'b1;
                if (resFire && (rcnt == 2'd3)) begin
                    stateNext = LOAD;
                end
            end
            default: stateNext = LOAD;
        endcase
    end

    // Word loading. Key and data keep their own counters so a key update can
    // be slipped in between data words without losing the data position.
    // ~cnt selects the 32-bit lane so word 0 lands in bits [127:96].
    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            keyBuf   <= '0;
            dataBuf  <= '0;
            kcnt     <= 2'd0;
            dcnt     <= 2'd0;
            keyValid <= 1'b0;
        end else if (wordFire) begin
            if (inWordIsKey) begin
                keyBuf[{~kcnt, 5'd0} +: 32] <= inWordData;
                kcnt <= kcnt + 2'd1;
                if (kcnt == 2'd0) begin
                    keyValid <= 1'b0;
                end else if (kcnt == 2'd3) begin
                    keyValid <= 1'b1;
                end
            end else begin
                dataBuf[{~dcnt, 5'd0} +: 32] <= inWordData;
                dcnt <= dcnt + 2'd1;
            end
        end
    end

    // Timeout counter restarts on entry to each wait state. A timeout
    // raises the sticky error; only reset clears it.
    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            tcnt    <= 8'd0;
            errFlag <= 1'b0;
        end else begin
            if ((state == FIRE) || ((state == WAIT_HI) && inCoreBusy)) begin
                tcnt <= 8'd0;
            end else if (inWait) begin
                tcnt <= tcnt + 8'd1;
            end
            if (inWait && (stateNext == LOAD)) begin
                errFlag <= 1'b1;
            end
        end
    end

    // Ciphertext capture on the busy falling edge, then the result word
    // pointer, which wraps back to word 0 after the fourth transfer.
    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            resReg <= '0;
            rcnt   <= 2'd0;
        end else begin
            if ((state == WAIT_LO) && !inCoreBusy) begin
                resReg <= inCoreData;
            end
            if (resFire) begin
                rcnt <= rcnt + 2'd1;
            end
        end
    end

endmodule
